// File: rtl/instruction_fetch.sv
// Instruction fetch front end: issues credit-limited reads to the instruction
// memory, buffers the one-cycle-latency responses and hands them to decode.
module instruction_fetch #(
    parameter int ADDRESS_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDRESS_WIDTH+1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       im_ce,
    output logic [ADDRESS_WIDTH-1:0]   im_address,
    input  logic [DATA_WIDTH-1:0]      im_data,
    input  logic                       im_dataValid,
    input  logic                       redirect_valid,
    input  logic [ADDRESS_WIDTH+1:0]   redirect_pc,
    output logic                       inst_valid,
    input  logic                       inst_ready,
    output logic [DATA_WIDTH-1:0]      inst_data,
    output logic [ADDRESS_WIDTH+1:0]   inst_pc
);

    localparam int PC_WIDTH = ADDRESS_WIDTH + 2;
    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam int CNT_WIDTH = $clog2(DEPTH + 1);
    localparam logic [CNT_WIDTH:0] CREDIT_LIMIT = (CNT_WIDTH + 1)'(DEPTH);

    logic [PC_WIDTH-1:0]   r_pc;
    logic [PC_WIDTH-1:0]   r_pendingPc;
    logic                  r_pending;
    logic [DATA_WIDTH-1:0] r_fifoData [DEPTH];
    logic [PC_WIDTH-1:0]   r_fifoPc [DEPTH];
    logic [PTR_WIDTH-1:0]  r_rdPtr;
    logic [PTR_WIDTH-1:0]  r_wrPtr;
    logic [CNT_WIDTH-1:0]  r_count;

    logic [CNT_WIDTH:0]    w_inFlight;
    logic                  w_issue;
    logic                  w_push;
    logic                  w_pop;
    logic [PC_WIDTH-1:0]   w_redirectPc;

    // A read is only issued if its response is guaranteed a FIFO slot,
    // counting the one already in flight.
    assign w_inFlight   = {1'b0, r_count} + {{CNT_WIDTH{1'b0}}, r_pending};
    assign w_issue      = !rst && !redirect_valid && (w_inFlight < CREDIT_LIMIT);
    assign w_push       = r_pending && im_dataValid && !redirect_valid;
    assign w_pop        = (r_count != '0) && inst_ready && !redirect_valid;
    assign w_redirectPc = redirect_pc & ~(PC_WIDTH'(3));

    assign im_ce      = w_issue;
    assign im_address = r_pc[PC_WIDTH-1:2];
    assign inst_valid = (r_count != '0);
    assign inst_data  = r_fifoData[r_rdPtr];
    assign inst_pc    = r_fifoPc[r_rdPtr];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc <= RESET_PC;
        end else if (redirect_valid) begin
            r_pc <= w_redirectPc;
        end else if (w_issue) begin
            r_pc <= r_pc + PC_WIDTH'(4);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending   <= 1'b0;
            r_pendingPc <= '0;
        end else begin
            r_pending <= w_issue;
            if (w_issue) begin
                r_pendingPc <= r_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifoData[i] <= '0;
                r_fifoPc[i]   <= '0;
            end
        end else if (w_push) begin
            r_fifoData[r_wrPtr] <= im_data;
            r_fifoPc[r_wrPtr]   <= r_pendingPc;
        end
    end

    // A redirect discards everything buffered; the stale in-flight response
    // is dropped because pending is cleared at the same edge.
    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTR_WIDTH'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTR_WIDTH'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_WIDTH'(1);
                2'b01:   r_count <= r_count - CNT_WIDTH'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed steps plus a scoreboard
// of expected (data, pc) pairs built from an independent PC model.
module tb_instruction_fetch;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [DW-1:0]   data;
        logic [AW+1:0]   pc;
    } expT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst = 1'b1;
    logic            imCe;
    logic [AW-1:0]   imAddress;
    logic [DW-1:0]   imData = '0;
    logic            imDataValid = 1'b0;
    logic            redirectValid = 1'b0;
    logic [AW+1:0]   redirectPc = '0;
    logic            instValid;
    logic            instReady = 1'b1;
    logic [DW-1:0]   instData;
    logic [AW+1:0]   instPc;

    logic            wImCe;
    logic [AW-1:0]   wImAddress;
    logic [DW-1:0]   wImData = '0;
    logic            wImDataValid = 1'b0;
    logic            wRedirectValid = 1'b0;
    logic [AW+1:0]   wRedirectPc = '0;
    logic            wInstValid;
    logic            wInstReady = 1'b1;
    logic [DW-1:0]   wInstData;
    logic [AW+1:0]   wInstPc;

    int checks = 0;
    int errors = 0;
    expT sbQ[$];
    logic [AW+1:0] modelPc = '0;

    instruction_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(12'h000)) dut (
        .clk(clk), .rst(rst), .im_ce(imCe), .im_address(imAddress), .im_data(imData),
        .im_dataValid(imDataValid), .redirect_valid(redirectValid), .redirect_pc(redirectPc),
        .inst_valid(instValid), .inst_ready(instReady), .inst_data(instData), .inst_pc(instPc)
    );

    instruction_fetch #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .RESET_PC(12'hFFC)) dutWrap (
        .clk(clk), .rst(rst), .im_ce(wImCe), .im_address(wImAddress), .im_data(wImData),
        .im_dataValid(wImDataValid), .redirect_valid(wRedirectValid), .redirect_pc(wRedirectPc),
        .inst_valid(wInstValid), .inst_ready(wInstReady), .inst_data(wInstData), .inst_pc(wInstPc)
    );

    // Memory model: word at address a holds 0x1000 + a, one-cycle latency.
    always @(posedge clk) begin
        imData       <= 32'h1000 + DW'(imAddress);
        imDataValid  <= imCe;
        wImData      <= 32'h1000 + DW'(wImAddress);
        wImDataValid <= wImCe;
    end

    function automatic logic [DW-1:0] memWord(input logic [AW+1:0] pc);
        return 32'h1000 + DW'(pc[AW+1:2]);
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: expectations are pushed as reads are issued, popped on handshake.
    always @(negedge clk) begin
        if (rst) begin
            sbQ.delete();
            modelPc = 12'h000;
        end else if (redirectValid) begin
            checkOutput("redirectNoIssue", 64'(imCe), 64'd0);
            sbQ.delete();
            modelPc = redirectPc & ~12'h003;
        end else begin
            if (instValid && instReady) begin
                checks++;
                assert (sbQ.size() != 0) else begin
                    errors++;
                    $error("[TB] FAIL sbUnderflow: observed pc %0h expected no output", instPc);
                end
                if (sbQ.size() != 0) begin
                    expT e;
                    e = sbQ.pop_front();
                    checkOutput("sbPc", 64'(instPc), 64'(e.pc));
                    checkOutput("sbData", 64'(instData), 64'(e.data));
                end
            end
            if (imCe) begin
                checkOutput("issueAddr", 64'(imAddress), 64'(modelPc[AW+1:2]));
                sbQ.push_back('{data: memWord(modelPc), pc: modelPc});
                modelPc = modelPc + 12'd4;
            end
        end
    end

    // One cycle: drive inputs just after the rising edge, return at the falling edge.
    task automatic applyStimulus(input logic rstV, input logic readyV, input logic redirV,
                                 input logic [AW+1:0] redirPcV);
        @(posedge clk);
        #1;
        rst           = rstV;
        instReady     = readyV;
        redirectValid = redirV;
        redirectPc    = redirPcV;
        @(negedge clk);
    endtask

    initial begin
        $display("[TB] start");
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        applyStimulus(1'b1, 1'b1, 1'b0, '0);
        checkOutput("rstCe", 64'(imCe), 64'd0);
        checkOutput("rstValid", 64'(instValid), 64'd0);
        checkOutput("rstData", 64'(instData), 64'd0);
        checkOutput("rstPc", 64'(instPc), 64'd0);

        // Sequential fetch with a redirect to 0x40 at cycle 5; wrap instance alongside.
        for (int cyc = 0; cyc <= 12; cyc++) begin
            applyStimulus(1'b0, 1'b1, (cyc == 5), 12'h040);
            case (cyc)
                0: begin
                    checkOutput("c0Ce", 64'(imCe), 64'd1);
                    checkOutput("c0Addr", 64'(imAddress), 64'd0);
                    checkOutput("c0Valid", 64'(instValid), 64'd0);
                    checkOutput("wrapAddr0", 64'(wImAddress), 64'd1023);
                end
                1: begin
                    checkOutput("c1Addr", 64'(imAddress), 64'd1);
                    checkOutput("c1Valid", 64'(instValid), 64'd0);
                    checkOutput("wrapAddr1", 64'(wImAddress), 64'd0);
                end
                2: begin
                    checkOutput("c2Valid", 64'(instValid), 64'd1);
                    checkOutput("c2Pc", 64'(instPc), 64'h000);
                    checkOutput("c2Data", 64'(instData), 64'h1000);
                    checkOutput("wrapAddr2", 64'(wImAddress), 64'd1);
                    checkOutput("wrapPc0", 64'(wInstPc), 64'hFFC);
                    checkOutput("wrapData0", 64'(wInstData), 64'h13FF);
                end
                3: begin
                    checkOutput("c3Valid", 64'(instValid), 64'd1);
                    checkOutput("wrapPc1", 64'(wInstPc), 64'h000);
                end
                4: begin
                    checkOutput("c4Valid", 64'(instValid), 64'd1);
                    checkOutput("wrapPc2", 64'(wInstPc), 64'h004);
                end
                5: checkOutput("redirCe", 64'(imCe), 64'd0);
                6: begin
                    checkOutput("redirAddr", 64'(imAddress), 64'h10);
                    checkOutput("redirCe1", 64'(imCe), 64'd1);
                    checkOutput("redirFlushed", 64'(instValid), 64'd0);
                end
                7: checkOutput("redirGap", 64'(instValid), 64'd0);
                8: begin
                    checkOutput("redirPc", 64'(instPc), 64'h040);
                    checkOutput("redirData", 64'(instData), 64'h1010);
                end
                default: checkOutput("streamValid", 64'(instValid), 64'd1);
            endcase
        end

        // Unaligned redirect with ready high: no pop, restart at 0x40.
        applyStimulus(1'b0, 1'b1, 1'b1, 12'h043);
        checkOutput("unalHeldValid", 64'(instValid), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("unalAddr", 64'(imAddress), 64'h10);
        checkOutput("unalFlushed", 64'(instValid), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("unalPc", 64'(instPc), 64'h040);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);

        // Backpressure from reset: four reads, then credit exhausted.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        for (int cyc = 0; cyc <= 7; cyc++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, '0);
            checkOutput("bpCe", 64'(imCe), (cyc < 4) ? 64'd1 : 64'd0);
            if (cyc >= 2) checkOutput("bpHeadPc", 64'(instPc), 64'h000);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("bpPopCe", 64'(imCe), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("bpRefillCe", 64'(imCe), 64'd1);
        checkOutput("bpRefillAddr", 64'(imAddress), 64'd4);
        checkOutput("bpNextHead", 64'(instPc), 64'h004);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("bpFullCe", 64'(imCe), 64'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, '0);
        checkOutput("bpFullCe2", 64'(imCe), 64'd0);
        for (int cyc = 0; cyc < 8; cyc++) applyStimulus(1'b0, 1'b1, 1'b0, '0);

        // Reset mid-stream with three entries buffered and one read in flight.
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        for (int cyc = 0; cyc <= 3; cyc++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
        applyStimulus(1'b1, 1'b0, 1'b0, '0);
        checkOutput("midRstCe", 64'(imCe), 64'd0);
        checkOutput("midRstPreValid", 64'(instValid), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("midRstValid", 64'(instValid), 64'd0);
        checkOutput("midRstRefetch", 64'(imAddress), 64'd0);
        checkOutput("midRstRefetchCe", 64'(imCe), 64'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("midRstGap", 64'(instValid), 64'd0);
        applyStimulus(1'b0, 1'b1, 1'b0, '0);
        checkOutput("midRstPc", 64'(instPc), 64'h000);
        for (int cyc = 0; cyc < 4; cyc++) applyStimulus(1'b0, 1'b1, 1'b0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
